// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key-search pipeline.
package rc4_pkg;

    localparam int MSG_LEN = 32;

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_A     = 8'h61;
    localparam logic [7:0] CHAR_Z     = 8'h7A;

    // Bit 3 = RAM ownership (mem_handler), bit 2 = finish; low bits just keep codes unique.
    typedef enum logic [3:0] {
        ST_IDLE     = 4'b0000,
        ST_SET_ADDR = 4'b1000,
        ST_WAIT_RD  = 4'b1001,
        ST_CHECK    = 4'b1010,
        ST_DONE     = 4'b0100
    } chk_state_e;

    localparam int ST_BIT_MEM_HANDLER = 3;
    localparam int ST_BIT_FINISH      = 2;

endpackage

// File: rtl/msg_char_legal.sv
// Legibility test for one plaintext byte: lowercase 'a'..'z' or space.
module msg_char_legal
    import rc4_pkg::*;
(
    input  logic [7:0] char_i,
    output logic       legal_o
);

    assign legal_o = (char_i == CHAR_SPACE) || ((char_i >= CHAR_A) && (char_i <= CHAR_Z));

endmodule

// File: rtl/decrypt_result_checker.sv
// Scans the decrypted-message RAM and reports whether every byte is legible.
// Define CHECKER_EARLY_ABORT_EN to stop the scan at the first illegal byte.
module decrypt_result_checker
    import rc4_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int MSG_LEN_P = MSG_LEN
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [7:0]        q_data_i,
    output logic [ADDR_W-1:0] address_o,
    output logic              mem_handler_o,
    output logic              finish_o,
    output logic              valid_o,
    output logic [ADDR_W-1:0] bad_index_o,
    output logic [ADDR_W:0]   bad_count_o
);

    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(MSG_LEN_P - 1);
    localparam logic [ADDR_W-1:0] IDX_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    chk_state_e        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] bad_index_q, bad_index_d;
    logic [ADDR_W:0]   bad_count_q, bad_count_d;
    logic              seen_bad_q, seen_bad_d;
    logic              char_legal;

    msg_char_legal u_char_legal (
        .char_i  (q_data_i),
        .legal_o (char_legal)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            bad_index_q <= '0;
            bad_count_q <= '0;
            seen_bad_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            bad_index_q <= bad_index_d;
            bad_count_q <= bad_count_d;
            seen_bad_q  <= seen_bad_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        bad_index_d = bad_index_q;
        bad_count_d = bad_count_q;
        seen_bad_d  = seen_bad_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    idx_d       = '0;
                    bad_index_d = '0;
                    bad_count_d = '0;
                    seen_bad_d  = 1'b0;
                    state_d     = ST_SET_ADDR;
                end
            end
            ST_SET_ADDR: state_d = ST_WAIT_RD;
            ST_WAIT_RD:  state_d = ST_CHECK;
            ST_CHECK: begin
                if (!char_legal) begin
                    bad_count_d = bad_count_q + COUNT_ONE;
                    if (!seen_bad_q) begin
                        bad_index_d = idx_q;
                        seen_bad_d  = 1'b1;
                    end
                end
`ifdef CHECKER_EARLY_ABORT_EN
                if (!char_legal || (idx_q == LAST_IDX)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                    state_d = ST_SET_ADDR;
                end
`else
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                    state_d = ST_SET_ADDR;
                end
`endif
            end
            ST_DONE: begin
                // Clearing on exit keeps every output at 0 while idle.
                if (!start_i) begin
                    idx_d       = '0;
                    bad_index_d = '0;
                    bad_count_d = '0;
                    seen_bad_d  = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign address_o     = idx_q;
    assign mem_handler_o = state_q[ST_BIT_MEM_HANDLER];
    assign finish_o      = state_q[ST_BIT_FINISH];
    assign valid_o       = state_q[ST_BIT_FINISH] && (bad_count_q == '0);
    assign bad_index_o   = bad_index_q;
    assign bad_count_o   = bad_count_q;

endmodule

// File: tb/tb_decrypt_result_checker.sv
// Self-checking bench for decrypt_result_checker: table vectors, random messages, corner sequences.
module tb_decrypt_result_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] q_data;
    logic [4:0] address;
    logic       mem_handler;
    logic       finish;
    logic       valid;
    logic [4:0] bad_index;
    logic [5:0] bad_count;

    logic [7:0] mem [32];

`ifdef CHECKER_EARLY_ABORT_EN
    localparam bit EA = 1'b1;
`else
    localparam bit EA = 1'b0;
`endif

    decrypt_result_checker dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .start_i       (start),
        .q_data_i      (q_data),
        .address_o     (address),
        .mem_handler_o (mem_handler),
        .finish_o      (finish),
        .valid_o       (valid),
        .bad_index_o   (bad_index),
        .bad_count_o   (bad_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) q_data <= mem[address];

    typedef struct {
        string        name;
        logic [255:0] msg;
        bit           exp_valid;
        int           exp_idx;
        int           exp_cnt;
        int           exp_lat;
    } vec_t;

    vec_t vecs[5];
    int   total  = 0;
    int   passed = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    function automatic logic [255:0] fill(input logic [7:0] b);
        logic [255:0] r;
        for (int k = 0; k < 32; k++) r[8*k +: 8] = b;
        return r;
    endfunction

    task automatic load(input logic [255:0] m);
        for (int k = 0; k < 32; k++) mem[k] = m[8*k +: 8];
    endtask

    // Reference: apply the legibility rule to each stored byte in order.
    task automatic model(output bit v, output int idx, output int cnt, output int lat);
        logic [7:0] b;
        bit legal;
        cnt = 0;
        idx = 0;
        lat = 3 * 32 + 1;
        for (int k = 0; k < 32; k++) begin
            b = mem[k];
            legal = (b == 8'h20) || (b >= 8'h61 && b <= 8'h7A);
            if (!legal) begin
                if (cnt == 0) idx = k;
                cnt++;
                if (EA) begin
                    lat = 3 * (k + 1) + 1;
                    break;
                end
            end
        end
        v = (cnt == 0);
    endtask

    task automatic run_scan(input int pulse_at, input bit hold, output int lat);
        int c;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        c = 1;
        chk("mem_handler_cycle1", int'(mem_handler), 1);
        chk("address_cycle1", int'(address), 0);
        start = hold || (c == pulse_at);
        while (!finish && c < 300) begin
            @(negedge clk);
            c++;
            start = hold || (c == pulse_at);
        end
        if (!finish) chk("finish_timeout", 0, 1);
        lat = c;
    endtask

    task automatic check_result(input string nm, input int lat, input bit ev, input int ei,
                                input int ec, input int el);
        chk({nm, "_latency"}, lat, el);
        chk({nm, "_valid"}, int'(valid), int'(ev));
        chk({nm, "_bad_index"}, int'(bad_index), ei);
        chk({nm, "_bad_count"}, int'(bad_count), ec);
        chk({nm, "_mem_handler_done"}, int'(mem_handler), 0);
        $display("scan %s: latency=%0d valid=%0d bad_index=%0d bad_count=%0d",
                 nm, lat, valid, bad_index, bad_count);
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_mem_handler"}, int'(mem_handler), 0);
        chk({nm, "_finish"}, int'(finish), 0);
        chk({nm, "_valid"}, int'(valid), 0);
        chk({nm, "_bad_index"}, int'(bad_index), 0);
        chk({nm, "_bad_count"}, int'(bad_count), 0);
        chk({nm, "_address"}, int'(address), 0);
    endtask

    initial begin
        string        s;
        logic [255:0] m;
        int           lat, ei, ec, el, c;
        bit           ev;

        s = "attack at dawn";
        m = fill(8'h20);
        for (int k = 0; k < s.len(); k++) m[8*k +: 8] = s[k];
        vecs[0] = '{"attack_at_dawn", m, 1'b1, 0, 0, 97};

        m = fill(8'h61);
        m[8*5 +: 8] = 8'h41;
        vecs[1] = '{"upper_A_at_5", m, 1'b0, 5, 1, EA ? 19 : 97};

        m = fill(8'h61);
        m[8*3 +: 8]  = 8'h7B;
        m[8*10 +: 8] = 8'h7B;
        m[8*31 +: 8] = 8'h7B;
        vecs[2] = '{"brace_3_10_31", m, 1'b0, 3, EA ? 1 : 3, EA ? 13 : 97};

        m = fill(8'h20);
        m[8*0 +: 8] = 8'h60;
        m[8*1 +: 8] = 8'h61;
        m[8*2 +: 8] = 8'h7A;
        m[8*7 +: 8] = 8'h7B;
        vecs[3] = '{"boundaries", m, 1'b0, 0, EA ? 1 : 2, EA ? 4 : 97};

        vecs[4] = '{"all_z", fill(8'h7A), 1'b1, 0, 0, 97};

        reset = 1'b1;
        start = 1'b0;
        load(fill(8'h20));
        repeat (2) @(negedge clk);
        check_all_zero("reset_state");
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            load(vecs[i].msg);
            run_scan(0, 1'b0, lat);
            check_result(vecs[i].name, lat, vecs[i].exp_valid, vecs[i].exp_idx,
                         vecs[i].exp_cnt, vecs[i].exp_lat);
        end

        for (int n = 0; n < 20; n++) begin
            for (int k = 0; k < 32; k++) begin
                int r;
                r = $urandom_range(0, 15);
                if (r == 0)      mem[k] = 8'($urandom_range(0, 255));
                else if (r < 4)  mem[k] = 8'h20;
                else             mem[k] = 8'(8'h61 + $urandom_range(0, 25));
            end
            model(ev, ei, ec, el);
            run_scan(0, 1'b0, lat);
            check_result($sformatf("random_%0d", n), lat, ev, ei, ec, el);
        end

        // Reset mid-scan must wipe a scan that already found bad bytes.
        load(vecs[2].msg);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 1;
        while (c < 40) begin
            @(negedge clk);
            c++;
        end
        chk("pre_reset_mem_handler", int'(mem_handler), 1);
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        reset = 1'b0;
        load(vecs[0].msg);
        run_scan(0, 1'b0, lat);
        check_result("after_reset", lat, 1'b1, 0, 0, 97);

        // Start held high through the scan and DONE.
        load(vecs[2].msg);
        model(ev, ei, ec, el);
        run_scan(0, 1'b1, lat);
        check_result("held_start", lat, ev, ei, ec, el);
        repeat (5) @(negedge clk);
        chk("held_finish", int'(finish), 1);
        chk("held_bad_count", int'(bad_count), ec);
        chk("held_bad_index", int'(bad_index), ei);
        start = 1'b0;
        @(negedge clk);
        check_all_zero("release_idle");

        // A start pulse mid-scan is ignored.
        load(vecs[1].msg);
        model(ev, ei, ec, el);
        run_scan(EA ? 8 : 20, 1'b0, lat);
        check_result("mid_pulse", lat, ev, ei, ec, el);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/decrypt_result_checker.md
# decrypt_result_checker

Reads back the 32-byte plaintext that the RC4 decrypt stage writes into decrypted-message RAM and decides whether it is legible: every byte is lowercase ASCII 'a'–'z' or space. It sits after the decrypt stage in the key-search loop. The top-level controller pulses `start` once decryption finishes. It then reads `valid`/`bad_index` to accept the key or try the next one. The block is a pure reader: it drives the RAM address and an ownership flag, and never writes.

## Interface
- `MSG_LEN`, 32 — number of message bytes scanned.
- `ADDR_W`, 5 — RAM address width; `MSG_LEN` ≤ 2^`ADDR_W`.
- `clk` in 1 — the only clock; all state updates on the rising edge.
- `reset` in 1 — asynchronous, active-high; returns the block to IDLE.
- `start` in 1 — begin a scan; sampled only in IDLE.
- `q_data` in 8 — registered read data from the decrypted-message RAM.
- `address` out `ADDR_W` — RAM read address.
- `mem_handler` out 1 — high while the block owns the RAM port; the top-level mux selects this block's `address` when it is high.
- `finish` out 1 — scan complete; results are stable.
- `valid` out 1 — all scanned bytes are legal; meaningful only when `finish` = 1.
- `bad_index` out `ADDR_W` — index of the first illegal byte; 0 if none.
- `bad_count` out `ADDR_W+1` — number of illegal bytes found.

## Operation
- State machine:
  - IDLE, then SET_ADDR, then WAIT_RD, then CHECK, then either SET_ADDR again or DONE.
  - Encode `mem_handler` and `finish` in the state bits.
- IDLE:
  - All outputs are 0.
  - On `start` = 1: clear the index, `bad_count` and `bad_index`, set the seen-bad flag to 0, and go to SET_ADDR.
- SET_ADDR: `address` = index; go to WAIT_RD.
- WAIT_RD: `address` is held while the RAM registers its output; go to CHECK.
- CHECK: sample `q_data`. A byte is legal if it is 0x20, or 0x61 ≤ byte ≤ 0x7A.
  - Illegal byte:
    - Increment `bad_count`.
    - If this is the first bad byte, latch `bad_index` = index and set the seen-bad flag.
  - If index = `MSG_LEN`−1, go to DONE.
  - Otherwise, increment the index and go to SET_ADDR.
- DONE:
  - `finish` = 1 and `mem_handler` = 0.
  - `valid` = (`bad_count` == 0).
  - `address` holds its last value.
  - Results are held while `start` = 1. Go to IDLE when `start` = 0.
- `start` is ignored in every state except IDLE and DONE. A held-high `start` does not retrigger until it has been low for at least one cycle.
- The index counter is `ADDR_W` bits and never wraps; the terminal test stops it at `MSG_LEN`−1.
- `bad_count` is `ADDR_W+1` bits, so it holds `MSG_LEN` without overflow.

## Timing
- `mem_handler` rises the cycle after `start` is sampled and stays high through the last CHECK.
- Each byte takes 3 cycles. `address` for byte k is valid in cycles 3k+1 and 3k+2, counting cycle 1 as the cycle after `start` is sampled.
- Full-scan latency: `finish` rises in cycle 3·`MSG_LEN`+1, which is 97 for the defaults.
- Required RAM latency: exactly 1 cycle from `address` to `q_data`. `q_data` is sampled only in CHECK.
- `reset` asserted at any time:
  - The state goes to IDLE immediately (asynchronous), and all outputs clear to 0.
  - No partial result survives the reset.

## Configuration
- `CHECKER_EARLY_ABORT_EN`:
  - Defined: the first illegal byte sends CHECK straight to DONE. `bad_count` = 1 and `bad_index` = the failing index. Latency is 3·(`bad_index`+1)+1.
  - Undefined: the block always scans all `MSG_LEN` bytes, and `bad_count` is the full count.
- In both cases `valid` and the all-legal latency are identical.

## Structure
- Shared package `rc4_pkg`:
  - the state encoding type;
  - `MSG_LEN`;
  - character constants `CHAR_SPACE` = 0x20, `CHAR_A` = 0x61, `CHAR_Z` = 0x7A.
- One combinational sub-module, `msg_char_legal`: 8-bit in, 1-bit legal out. It is reused later by the key-search controller.

## Test plan
- RAM holds "attack at dawn" padded with spaces to 32 bytes; pulse `start` → `finish` at cycle 97, `valid` = 1, `bad_count` = 0, `bad_index` = 0.
- Byte 5 = 0x41, all others 'a':
  - Without the macro: `finish` at cycle 97, `valid` = 0, `bad_index` = 5, `bad_count` = 1.
  - With the macro: `finish` at cycle 19, same outputs.
- Bytes 3, 10 and 31 = 0x7B, without the macro → `bad_index` = 3, `bad_count` = 3. Boundary bytes 0x60 and 0x7B are illegal; 0x61 and 0x7A are legal.
- `reset` asserted in cycle 40 of a scan → all outputs 0 in the same cycle. A new `start` then gives a clean full result at cycle 97.
- `start` held high through DONE → the block stays in DONE with results stable. Dropping `start` → IDLE with all outputs 0. Pulsing `start` mid-scan has no effect.
